// File: rtl/loader_pkg.sv
// Shared types and default constants for the HPS ROM download path.
package loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DRAIN,
    ST_HOLD,
    ST_DONE
  } state_t;

  localparam int unsigned DEF_ADDR_LIMIT  = 262144;
  localparam int unsigned DEF_HOLD_CYCLES = 16;
  localparam int unsigned DEF_FIFO_DEPTH  = 4;
  localparam int unsigned ENTRY_W         = 26;

  typedef struct packed {
    logic [17:0] addr;
    logic [7:0]  data;
  } entry_t;

endpackage

// File: rtl/loader_fifo.sv
// Small synchronous FIFO; a push into a full FIFO is taken only when a pop
// frees a slot in the same cycle.
module loader_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 26
) (
  input  logic             clock_12,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clock_12) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clock_12 or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + (AW+1)'(1);
      else if (do_pop && !do_push) count <= count - (AW+1)'(1);
    end
  end

endmodule

// File: rtl/rom_loader.sv
// Buffers HPS ioctl ROM bytes into the core's ROM write port and holds the
// core in reset until the download has drained plus a settling period.
module rom_loader
  import loader_pkg::*;
#(
  parameter int unsigned LOAD_INDEX  = 0,
  parameter int unsigned ADDR_LIMIT  = DEF_ADDR_LIMIT,
  parameter int unsigned HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int unsigned FIFO_DEPTH  = DEF_FIFO_DEPTH
) (
  input  logic        clock_12,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [15:0] ioctl_index,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic [17:0] dn_addr,
  output logic [7:0]  dn_data,
  output logic        dn_wr,
  input  logic        dn_ready,
  output logic        core_reset,
  output logic        rom_loaded,
  output logic        load_err,
  output logic [18:0] byte_count
);

  state_t      state;
  logic [15:0] hold_cnt;
  entry_t      in_entry;
  entry_t      head_entry;
  logic        fifo_full;
  logic        fifo_empty;
  logic        fifo_push;
  logic        index_match;
  logic        start;
  logic        strobe;
  logic        in_range;
  logic        pop;
  logic        bypass;
  logic        accept;
  logic        drop;

  assign index_match = (ioctl_index == 16'(LOAD_INDEX));
  assign start       = ioctl_download && index_match;
  assign strobe      = (state == ST_LOAD) && ioctl_download && ioctl_wr && index_match;
  assign in_range    = ({7'd0, ioctl_addr} < ADDR_LIMIT);
  assign in_entry    = '{addr: ioctl_addr[17:0], data: ioctl_dout};

  // An in-range byte arriving at an empty FIFO with the core ready skips the
  // FIFO entirely, giving the one-cycle strobe-to-write latency.
  assign pop       = dn_ready && !fifo_empty;
  assign bypass    = dn_ready && fifo_empty && strobe && in_range;
  assign accept    = strobe && in_range && (!fifo_full || pop);
  assign drop      = strobe && (!in_range || (fifo_full && !pop));
  assign fifo_push = accept && !bypass;

  loader_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clock_12 (clock_12),
    .reset_n  (reset_n),
    .push     (fifo_push),
    .din      (in_entry),
    .pop      (pop),
    .head     (head_entry),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_ff @(posedge clock_12 or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      hold_cnt   <= '0;
      dn_wr      <= 1'b0;
      dn_addr    <= '0;
      dn_data    <= '0;
      core_reset <= 1'b1;
      rom_loaded <= 1'b0;
      load_err   <= 1'b0;
      byte_count <= '0;
    end else begin
      dn_wr <= pop || bypass;
      if (pop) begin
        dn_addr <= head_entry.addr;
        dn_data <= head_entry.data;
      end else if (bypass) begin
        dn_addr <= in_entry.addr;
        dn_data <= in_entry.data;
      end

      // Any matching download restarts loading; buffered bytes keep draining.
      if (state != ST_LOAD && start) begin
        state      <= ST_LOAD;
        hold_cnt   <= '0;
        byte_count <= '0;
        load_err   <= 1'b0;
        core_reset <= 1'b1;
        rom_loaded <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: state <= ST_IDLE;
          ST_LOAD: begin
            if (accept && byte_count != '1) byte_count <= byte_count + 19'd1;
            if (drop) load_err <= 1'b1;
            if (!ioctl_download) state <= ST_DRAIN;
          end
          ST_DRAIN: begin
            if (fifo_empty && !dn_wr) begin
              state    <= ST_HOLD;
              hold_cnt <= 16'(HOLD_CYCLES);
            end
          end
          ST_HOLD: begin
            if (hold_cnt <= 16'd1) begin
              state      <= ST_DONE;
              hold_cnt   <= '0;
              core_reset <= 1'b0;
              rom_loaded <= 1'b1;
            end else begin
              hold_cnt <= hold_cnt - 16'd1;
            end
          end
          ST_DONE: state <= ST_DONE;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rom_loader.sv
// Randomised bench for rom_loader; a queue model predicts every core write.
module tb_rom_loader;

  localparam int LOAD_INDEX  = 0;
  localparam int ADDR_LIMIT  = 262144;
  localparam int HOLD_CYCLES = 16;
  localparam int FIFO_DEPTH  = 4;

  logic        clock_12 = 1'b0;
  logic        reset_n  = 1'b1;
  logic        ioctl_download = 1'b0;
  logic        ioctl_wr = 1'b0;
  logic [15:0] ioctl_index = '0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic [17:0] dn_addr;
  logic [7:0]  dn_data;
  logic        dn_wr;
  logic        dn_ready = 1'b1;
  logic        core_reset;
  logic        rom_loaded;
  logic        load_err;
  logic [18:0] byte_count;

  int vectors = 0;
  int miscompares = 0;

  logic [25:0] model_q[$];
  bit          in_load = 0;
  int          exp_count = 0;
  bit          exp_err = 0;
  logic [17:0] last_addr = '0;
  logic [7:0]  last_data = '0;
  int          cycle = 0;
  int          writes_seen = 0;
  int          last_write_cycle = -100;
  int          drain_obs = 0;

  rom_loader #(
    .LOAD_INDEX  (LOAD_INDEX),
    .ADDR_LIMIT  (ADDR_LIMIT),
    .HOLD_CYCLES (HOLD_CYCLES),
    .FIFO_DEPTH  (FIFO_DEPTH)
  ) dut (
    .clock_12       (clock_12),
    .reset_n        (reset_n),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_index    (ioctl_index),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .dn_addr        (dn_addr),
    .dn_data        (dn_data),
    .dn_wr          (dn_wr),
    .dn_ready       (dn_ready),
    .core_reset     (core_reset),
    .rom_loaded     (rom_loaded),
    .load_err       (load_err),
    .byte_count     (byte_count)
  );

  always #5 clock_12 = ~clock_12;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, observed, expected, cycle);
    end
  endtask

  // Drives one cycle of inputs, advances the model, then checks the outputs.
  task automatic applyStimulus(input bit dl, input bit wr, input logic [15:0] idx,
                               input logic [24:0] addr, input logic [7:0] dout, input bit ready);
    bit          strobe;
    bit          emit;
    bit          pop_now;
    bit          leaving;
    logic [25:0] head;
    ioctl_download = dl;
    ioctl_wr       = wr;
    ioctl_index    = idx;
    ioctl_addr     = addr;
    ioctl_dout     = dout;
    dn_ready       = ready;

    strobe = in_load && dl && wr && (idx == 16'(LOAD_INDEX));
    if (strobe) begin
      if (addr >= 25'(ADDR_LIMIT)) exp_err = 1;
      else begin
        pop_now = ready && (model_q.size() > 0);
        if (model_q.size() < FIFO_DEPTH || pop_now) begin
          model_q.push_back({addr[17:0], dout});
          if (exp_count < 524287) exp_count++;
        end else exp_err = 1;
      end
    end
    emit = ready && (model_q.size() > 0);
    if (emit) begin
      head      = model_q.pop_front();
      last_addr = head[25:8];
      last_data = head[7:0];
    end
    if (!in_load && dl && idx == 16'(LOAD_INDEX)) begin
      exp_count = 0;
      exp_err   = 0;
    end
    leaving = in_load && !dl;
    in_load = dl && (idx == 16'(LOAD_INDEX));

    @(posedge clock_12);
    #1;
    cycle++;
    if (leaving) drain_obs = cycle;
    checkOutput("dn_wr", 32'(dn_wr), 32'(emit));
    checkOutput("dn_addr", 32'(dn_addr), 32'(last_addr));
    checkOutput("dn_data", 32'(dn_data), 32'(last_data));
    checkOutput("byte_count", 32'(byte_count), 32'(exp_count));
    checkOutput("load_err", 32'(load_err), 32'(exp_err));
    if (emit) begin
      writes_seen++;
      last_write_cycle = cycle;
    end
  endtask

  task automatic idle(input int n, input bit ready);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 16'(LOAD_INDEX), '0, '0, ready);
  endtask

  task automatic resetDut();
    reset_n = 1'b0;
    ioctl_download = 1'b0;
    ioctl_wr = 1'b0;
    @(posedge clock_12);
    #1;
    cycle++;
    checkOutput("rst_dn_wr", 32'(dn_wr), 0);
    checkOutput("rst_dn_addr", 32'(dn_addr), 0);
    checkOutput("rst_dn_data", 32'(dn_data), 0);
    checkOutput("rst_core_reset", 32'(core_reset), 1);
    checkOutput("rst_rom_loaded", 32'(rom_loaded), 0);
    checkOutput("rst_load_err", 32'(load_err), 0);
    checkOutput("rst_byte_count", 32'(byte_count), 0);
    model_q.delete();
    in_load   = 0;
    exp_count = 0;
    exp_err   = 0;
    last_addr = '0;
    last_data = '0;
    reset_n   = 1'b1;
  endtask

  // Release happens HOLD_CYCLES+1 cycles after the first quiet DRAIN cycle.
  task automatic waitDone();
    int expected;
    int n;
    n = 0;
    while (!rom_loaded && n < 200) begin
      checkOutput("core_reset_busy", 32'(core_reset), 1);
      applyStimulus(0, 0, 16'(LOAD_INDEX), '0, '0, 1);
      n++;
    end
    if (!rom_loaded) begin
      checkOutput("done_timeout", 32'(rom_loaded), 1);
    end else begin
      expected = ((drain_obs > last_write_cycle + 1) ? drain_obs : last_write_cycle + 1) + 1 + HOLD_CYCLES;
      checkOutput("done_cycle", 32'(cycle), 32'(expected));
      checkOutput("done_core_reset", 32'(core_reset), 0);
    end
  endtask

  initial begin
    resetDut();
    idle(3, 1);

    $display("[TB] sequential download of 16 bytes");
    applyStimulus(1, 0, 16'(LOAD_INDEX), '0, '0, 1);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1, 1, 16'(LOAD_INDEX), 25'(i), 8'(8'hA0 + i), 1);
      applyStimulus((i != 15), 0, 16'(LOAD_INDEX), '0, '0, 1);
    end
    checkOutput("seq_count", 32'(byte_count), 16);
    waitDone();
    checkOutput("seq_rom_loaded", 32'(rom_loaded), 1);

    $display("[TB] overflow with core stalled");
    applyStimulus(1, 0, 16'(LOAD_INDEX), '0, '0, 0);
    checkOutput("reload_core_reset", 32'(core_reset), 1);
    checkOutput("reload_rom_loaded", 32'(rom_loaded), 0);
    for (int i = 0; i < 10; i++)
      applyStimulus(1, (i < 6), 16'(LOAD_INDEX), 25'($urandom_range(0, ADDR_LIMIT - 1)), 8'($urandom), 0);
    checkOutput("ovf_err", 32'(load_err), 1);
    checkOutput("ovf_count", 32'(byte_count), 4);
    writes_seen = 0;
    for (int i = 0; i < 8; i++) applyStimulus(1, 0, 16'(LOAD_INDEX), '0, '0, 1);
    checkOutput("ovf_writes", 32'(writes_seen), 4);
    idle(1, 1);

    $display("[TB] out-of-range address");
    applyStimulus(1, 0, 16'(LOAD_INDEX), '0, '0, 1);
    checkOutput("oor_err_clear", 32'(load_err), 0);
    writes_seen = 0;
    applyStimulus(1, 1, 16'(LOAD_INDEX), 25'h40000, 8'h5A, 1);
    applyStimulus(1, 0, 16'(LOAD_INDEX), '0, '0, 1);
    checkOutput("oor_err", 32'(load_err), 1);
    checkOutput("oor_count", 32'(byte_count), 0);
    checkOutput("oor_writes", 32'(writes_seen), 0);
    idle(1, 1);
    waitDone();

    $display("[TB] reset with bytes buffered");
    applyStimulus(1, 0, 16'(LOAD_INDEX), '0, '0, 0);
    for (int i = 0; i < 3; i++)
      applyStimulus(1, 1, 16'(LOAD_INDEX), 25'($urandom_range(0, ADDR_LIMIT - 1)), 8'($urandom), 0);
    checkOutput("pre_rst_count", 32'(byte_count), 3);
    resetDut();
    writes_seen = 0;
    idle(6, 1);
    checkOutput("post_rst_writes", 32'(writes_seen), 0);

    $display("[TB] foreign index download");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1, 0, 16'd1, '0, '0, 1);
      applyStimulus(1, 1, 16'd1, 25'(i), 8'($urandom), 1);
    end
    idle(2, 1);
    checkOutput("foreign_core_reset", 32'(core_reset), 1);
    checkOutput("foreign_rom_loaded", 32'(rom_loaded), 0);
    checkOutput("foreign_writes", 32'(writes_seen), 0);

    $display("[TB] restart during hold");
    applyStimulus(1, 0, 16'(LOAD_INDEX), '0, '0, 1);
    applyStimulus(1, 1, 16'(LOAD_INDEX), 25'h100, 8'h11, 1);
    applyStimulus(1, 1, 16'(LOAD_INDEX), 25'h1FFFFFF, 8'h22, 1);
    applyStimulus(0, 0, 16'(LOAD_INDEX), '0, '0, 1);
    idle(5, 1);
    checkOutput("hold_err_set", 32'(load_err), 1);
    checkOutput("hold_core_reset", 32'(core_reset), 1);
    applyStimulus(1, 0, 16'(LOAD_INDEX), '0, '0, 1);
    checkOutput("restart_count", 32'(byte_count), 0);
    checkOutput("restart_err", 32'(load_err), 0);
    checkOutput("restart_core_reset", 32'(core_reset), 1);
    checkOutput("restart_rom_loaded", 32'(rom_loaded), 0);
    applyStimulus(1, 1, 16'(LOAD_INDEX), 25'h200, 8'h33, 1);
    applyStimulus(0, 0, 16'(LOAD_INDEX), '0, '0, 1);
    waitDone();

    $display("[TB] random downloads");
    for (int d = 0; d < 4; d++) begin
      applyStimulus(1, 0, 16'(LOAD_INDEX), '0, '0, 1);
      for (int i = 0; i < 40; i++) begin
        logic [24:0] a;
        a = ($urandom_range(0, 15) == 0) ? 25'(ADDR_LIMIT + $urandom_range(0, 1000))
                                          : 25'($urandom_range(0, ADDR_LIMIT - 1));
        applyStimulus(1, 1'($urandom_range(0, 1)), 16'(LOAD_INDEX), a, 8'($urandom),
                      ($urandom_range(0, 3) != 0));
      end
      applyStimulus(0, 0, 16'(LOAD_INDEX), '0, '0, 1);
      waitDone();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
